serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//  Bit-serial add controller: accepts two WIDTH-bit operands plus carry-in, sequences
//  a single 1-bit full-adder cell LSB-first over WIDTH cycles, and returns sum/carry/overflow.
//  Sits between operand source and ALU result mux; trades latency for one adder cell.
//  Valid/ready on both input and output sides.
// PARAMETERS
//  WIDTH    4   operand/sum width in bits (>=2)
//  CNT_W    $clog2(WIDTH)   bit-counter width (derived, do not override)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      controller can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  c_in       in   1      carry-in (ignored when sub=1)
//  sub        in   1      subtract select (present only with SERIAL_SUB_EN)
//  out_valid  out  1      result valid, held until out_ready
//  out_ready  in   1      result consumer ready
//  sum        out  WIDTH  result
//  c_out      out  1      carry out of MSB (sub: 1 = no borrow)
//  ovf        out  1      signed overflow = carry-into-MSB ^ carry-out-of-MSB
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0,
//   bit counter=0, all operand/carry regs=0. Reset mid-operation aborts; no result issued.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE : in_ready=1. On in_valid&in_ready at edge T: load A,B shift regs, carry reg=c_in,
//          cnt=0, clear sum reg -> SHIFT.
//   SHIFT: in_ready=0. Each edge: fa(a_sr[0], b_sr[0], carry) -> sum shifted in at MSB,
//          a_sr/b_sr shift right, carry<=fa carry, prev_carry<=carry, cnt++.
//          After WIDTH SHIFT edges (cnt==WIDTH-1 processed) -> DONE; c_out=final carry,
//          ovf=prev_carry^final carry.
//   DONE : out_valid=1, outputs stable. On out_valid&out_ready -> IDLE, out_valid drops next edge.
//  Latency: out_valid rises WIDTH+1 edges after accept edge T. Min initiation interval WIDTH+2.
//  in_ready=0 in SHIFT and DONE; in_valid ignored there (no queueing, no same-cycle re-accept).
//  Backpressure: DONE holds indefinitely; sum/c_out/ovf must not change while out_valid=1.
//  sum/c_out/ovf registered; after handshake they retain last value until next DONE.
//  Arithmetic modulo 2^WIDTH; carry beyond MSB reported only on c_out.
// CONFIGURATION
//  SERIAL_SUB_EN defined: sub port exists, sampled with operands at accept; sub=1 -> B bits
//   inverted into cell, carry reg init=1 (c_in ignored); result = A-B mod 2^WIDTH.
//  SERIAL_SUB_EN undefined: no sub port; add only, carry init = c_in.
// STRUCTURE
//  Shared package/include serial_add_pkg: FSM state encodings (IDLE=2'd0, SHIFT=2'd1,
//   DONE=2'd2), CNT_W derivation helper.
//  One sub-module: serial_fa_cell (a, b, cin -> s, cout), combinational, instantiated once.
//  Controller owns FSM, counter, shift regs, carry regs, handshake logic.
// TESTING  (WIDTH=4)
//  a=3,b=5,c_in=0, out_ready=1 -> out_valid 5 edges after accept; sum=8,c_out=0,ovf=1.
//  a=15,b=1,c_in=0 -> sum=0,c_out=1,ovf=0; a=7,b=0,c_in=1 -> sum=8,c_out=0,ovf=1.
//  out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, new in_valid ignored;
//   release -> out_valid falls next edge, in_ready=1.
//  rst_n pulsed low during 2nd SHIFT cycle -> immediate IDLE, out_valid=0, sum=0; next op correct.
//  SERIAL_SUB_EN: a=5,b=7,sub=1 -> sum=14,c_out=0,ovf=0; a=8,b=1,sub=1 -> sum=7,c_out=1,ovf=1.
//  Back-to-back: in_valid held high for 3 ops -> each accepted exactly once, interval WIDTH+2.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add controller: FSM encodings and
// the bit-counter width derivation.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counter must index bits 0..w-1; keep at least one bit for narrow operands.
  function automatic int cnt_width(input int w);
    if (w <= 2) begin
      return 1;
    end else begin
      return $clog2(w);
    end
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Single 1-bit full-adder cell reused every cycle by the serial controller.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add controller with valid/ready on both sides.
// Optional subtract support is enabled by defining SERIAL_SUB_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_sr_r, a_sr_s;
  logic [WIDTH-1:0] b_sr_r, b_sr_s;
  logic [WIDTH-1:0] sum_sr_r, sum_sr_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             carry_r, carry_s;
  logic [WIDTH-1:0] sum_r, sum_s;
  logic             c_out_r, c_out_s;
  logic             ovf_r, ovf_s;
  logic             out_valid_r, out_valid_s;
  logic             in_ready_r, in_ready_s;
  logic             fa_s_s;
  logic             fa_cout_s;
  logic             sub_s;
  logic             accept_s;

  serial_fa_cell u_fa (
    .a    (a_sr_r[0]),
    .b    (b_sr_r[0]),
    .cin  (carry_r),
    .s    (fa_s_s),
    .cout (fa_cout_s)
  );

`ifdef SERIAL_SUB_EN
  assign sub_s = sub;
`else
  assign sub_s = 1'b0;
`endif

  assign accept_s = in_valid & in_ready_r;

  // Next-state and next-datapath values for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_s     = state_r;
    a_sr_s      = a_sr_r;
    b_sr_s      = b_sr_r;
    sum_sr_s    = sum_sr_r;
    cnt_s       = cnt_r;
    carry_s     = carry_r;
    sum_s       = sum_r;
    c_out_s     = c_out_r;
    ovf_s       = ovf_r;
    out_valid_s = out_valid_r;
    in_ready_s  = in_ready_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          // Subtract is A + ~B + 1, so B is inverted once at load time.
          a_sr_s     = a;
          b_sr_s     = sub_s ? ~b : b;
          carry_s    = sub_s ? 1'b1 : c_in;
          sum_sr_s   = '0;
          cnt_s      = '0;
          in_ready_s = 1'b0;
          state_s    = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        a_sr_s   = {1'b0, a_sr_r[WIDTH-1:1]};
        b_sr_s   = {1'b0, b_sr_r[WIDTH-1:1]};
        sum_sr_s = {fa_s_s, sum_sr_r[WIDTH-1:1]};
        carry_s  = fa_cout_s;
        cnt_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_r == CNT_W'(WIDTH - 1)) begin
          // carry_r here is the carry into the MSB cell.
          sum_s       = {fa_s_s, sum_sr_r[WIDTH-1:1]};
          c_out_s     = fa_cout_s;
          ovf_s       = carry_r ^ fa_cout_s;
          out_valid_s = 1'b1;
          cnt_s       = '0;
          state_s     = ST_DONE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          in_ready_s  = 1'b1;
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        out_valid_s = 1'b0;
        in_ready_s  = 1'b1;
        cnt_s       = '0;
        state_s     = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath, handshake and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_r      <= '0;
      b_sr_r      <= '0;
      sum_sr_r    <= '0;
      cnt_r       <= '0;
      carry_r     <= 1'b0;
      sum_r       <= '0;
      c_out_r     <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      a_sr_r      <= a_sr_s;
      b_sr_r      <= b_sr_s;
      sum_sr_r    <= sum_sr_s;
      cnt_r       <= cnt_s;
      carry_r     <= carry_s;
      sum_r       <= sum_s;
      c_out_r     <= c_out_s;
      ovf_r       <= ovf_s;
      out_valid_r <= out_valid_s;
      in_ready_r  <= in_ready_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign c_out     = c_out_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=4); subtract
// vectors run only when SERIAL_SUB_EN is defined.
module tb_serial_add_ctrl;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef SERIAL_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  int errors;
  int checks;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef SERIAL_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand set and return #1 after the accept edge.
  task automatic start_op(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                          input logic cc);
    @(negedge clk);
    a        = aa;
    b        = bb;
    c_in     = cc;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen; -1 on timeout.
  task automatic wait_valid(output int edges);
    edges = -1;
    for (int n = 0; n < 20; n++) begin
      if (out_valid === 1'b1) begin
        edges = n;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
`ifdef SERIAL_SUB_EN
    sub       = 1'b0;
`endif
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (sum !== 4'd0) begin errors++; $display("FAIL reset_sum: got %0d expected 0", sum); end
    checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL reset_c_out: got %b expected 0", c_out); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_vector(input string name, input logic [WIDTH-1:0] aa,
                                 input logic [WIDTH-1:0] bb, input logic cc,
                                 input logic [WIDTH-1:0] exp_sum, input logic exp_c,
                                 input logic exp_ovf);
    int edges;
    out_ready = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_before: got %b expected 1", name, in_ready); end
    start_op(aa, bb, cc);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_busy: in_ready got %b expected 0", name, in_ready); end
    wait_valid(edges);
    // Edge count includes the accept edge itself.
    checks++; if (edges + 1 != WIDTH + 1) begin errors++; $display("FAIL %s_latency: got %0d edges expected %0d", name, edges + 1, WIDTH + 1); end
    checks++; if (sum !== exp_sum) begin errors++; $display("FAIL %s_sum: got %0d expected %0d", name, sum, exp_sum); end
    checks++; if (c_out !== exp_c) begin errors++; $display("FAIL %s_c_out: got %b expected %b", name, c_out, exp_c); end
    checks++; if (ovf !== exp_ovf) begin errors++; $display("FAIL %s_ovf: got %b expected %b", name, ovf, exp_ovf); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL %s_handshake: out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready); end
    checks++; if (sum !== exp_sum) begin errors++; $display("FAIL %s_sum_retained: got %0d expected %0d", name, sum, exp_sum); end
  endtask

  task automatic test_backpressure();
    int edges;
    int bad;
    out_ready = 1'b0;
    start_op(4'd9, 4'd4, 1'b0);
    wait_valid(edges);
    checks++; if (edges != WIDTH) begin errors++; $display("FAIL bp_valid: got %0d edges expected %0d", edges, WIDTH); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = 4'(i);
      b        = 4'd3;
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 4'd13 || c_out !== 1'b0 || ovf !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles expected 0 (sum=%0d)", bad, sum); end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    repeat (WIDTH + 2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_queue: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    checks++; if (sum !== 4'd13) begin errors++; $display("FAIL bp_sum_retained: got %0d expected 13", sum); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    start_op(4'd15, 4'd15, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_hs: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    checks++; if (sum !== 4'd0) begin errors++; $display("FAIL mid_reset_sum: got %0d expected 0", sum); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (WIDTH + 3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_no_result: out_valid got %b expected 0", out_valid); end
    test_add_vector("after_reset", 4'd6, 4'd9, 1'b1, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] op_a [3];
    logic [WIDTH-1:0] op_b [3];
    logic             op_c [3];
    logic [WIDTH-1:0] exp_s [3];
    logic             exp_c [3];
    int acc_cyc [3];
    int cyc;
    int n_acc;
    int n_res;
    logic acc_now;
    op_a = '{4'd1, 4'd10, 4'd4};
    op_b = '{4'd2, 4'd5, 4'd4};
    op_c = '{1'b0, 1'b1, 1'b0};
    exp_s = '{4'd3, 4'd0, 4'd8};
    exp_c = '{1'b0, 1'b1, 1'b0};
    acc_cyc = '{0, 0, 0};
    cyc = 0;
    n_acc = 0;
    n_res = 0;
    out_ready = 1'b1;
    @(negedge clk);
    a = op_a[0]; b = op_b[0]; c_in = op_c[0];
    in_valid = 1'b1;
    while (cyc < 40 && n_res < 3) begin
      if (out_valid === 1'b1) begin
        checks++; if (sum !== exp_s[n_res] || c_out !== exp_c[n_res]) begin errors++; $display("FAIL b2b_result%0d: sum=%0d c_out=%b expected %0d/%b", n_res, sum, c_out, exp_s[n_res], exp_c[n_res]); end
        n_res++;
      end
      acc_now = 1'b0;
      if (in_valid === 1'b1 && in_ready === 1'b1 && n_acc < 3) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        acc_now = 1'b1;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (acc_now) begin
        if (n_acc < 3) begin
          a = op_a[n_acc]; b = op_b[n_acc]; c_in = op_c[n_acc];
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (n_acc != 3 || n_res != 3) begin errors++; $display("FAIL b2b_counts: accepts=%0d results=%0d expected 3/3", n_acc, n_res); end
    checks++; if (acc_cyc[1] - acc_cyc[0] != WIDTH + 2) begin errors++; $display("FAIL b2b_interval0: got %0d expected %0d", acc_cyc[1] - acc_cyc[0], WIDTH + 2); end
    checks++; if (acc_cyc[2] - acc_cyc[1] != WIDTH + 2) begin errors++; $display("FAIL b2b_interval1: got %0d expected %0d", acc_cyc[2] - acc_cyc[1], WIDTH + 2); end
  endtask

`ifdef SERIAL_SUB_EN
  task automatic test_sub();
    sub = 1'b1;
    test_add_vector("sub_5_7", 4'd5, 4'd7, 1'b0, 4'd14, 1'b0, 1'b0);
    test_add_vector("sub_8_1", 4'd8, 4'd1, 1'b0, 4'd7, 1'b1, 1'b1);
    sub = 1'b0;
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_add_vector("add_3_5", 4'd3, 4'd5, 1'b0, 4'd8, 1'b0, 1'b1);
    test_add_vector("add_15_1", 4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0);
    test_add_vector("add_7_0_ci", 4'd7, 4'd0, 1'b1, 4'd8, 1'b0, 1'b1);
    test_backpressure();
    test_reset_mid();
`ifdef SERIAL_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
